// File: rtl/fetch_pkg.sv
// Shared constants and next-PC source encodings for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_INSTR_W     = 19;
  localparam int DEF_STACK_DEPTH = 8;
  // Relative branches carry a 9-bit two's-complement offset in IR[8:0].
  localparam int OFFSET_W        = 9;

  typedef enum logic [1:0] {
    PC_INC     = 2'b00,
    PC_REL     = 2'b01,
    PC_ABS     = 2'b10,
    PC_INC_ALT = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Controller/instruction-memory bus of the fetch unit. The slave modport is the fetch unit.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  // There is no valid/ready pair here: every strobe (enablePC, push, pop, RET,
  // ir_load) is a single-cycle request that is always accepted at the next
  // rising edge, and imem_data must be valid combinationally for imem_addr.
  logic                enablePC;
  logic [1:0]          pc_sel;
  logic                push;
  logic                pop;
  logic                RET;
  logic                ir_load;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_data;
  logic [INSTR_W-1:0]  allBits;
  logic [ADDR_W-1:0]   pc;
  logic                stack_empty;
  logic                stack_full;
  logic                stack_err;

  modport master (
    output enablePC, pc_sel, push, pop, RET, ir_load, imem_data,
    input  imem_addr, allBits, pc, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  enablePC, pc_sel, push, pop, RET, ir_load, imem_data,
    output imem_addr, allBits, pc, stack_empty, stack_full, stack_err
  );

endinterface

// File: rtl/instr_fetch_unit_return_stack.sv
// Hardware return-address stack; TOS = stack[SP-1].
// FETCH_STACK_GUARD_EN: drop overflowing pushes / underflowing pops and raise sticky err.
module return_stack
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] tos,
  output logic              empty,
  output logic              full,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  spIdx;
  logic [IDX_W-1:0]  tosIdx;

  // Indexing uses only the low SP bits, so an unguarded stack wraps modulo DEPTH.
  assign spIdx  = sp[IDX_W-1:0];
  assign tosIdx = spIdx - IDX_W'(1);
  assign tos    = mem[tosIdx];
  assign empty  = (sp == '0);
  assign full   = (sp == SP_W'(DEPTH));

`ifdef FETCH_STACK_GUARD_EN
  logic errReg;
  assign err = errReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp     <= '0;
      errReg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop) begin
      if (empty) errReg <= 1'b1;
      else       mem[tosIdx] <= wdata;
    end else if (push) begin
      if (full) begin
        errReg <= 1'b1;
      end else begin
        mem[spIdx] <= wdata;
        sp         <= sp + SP_W'(1);
      end
    end else if (pop) begin
      if (empty) errReg <= 1'b1;
      else       sp <= sp - SP_W'(1);
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop) begin
      mem[tosIdx] <= wdata;
    end else if (push) begin
      mem[spIdx] <= wdata;
      sp         <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register, next-PC selection and return stack.
// FETCH_STACK_GUARD_EN enables over/underflow protection and the sticky stack_err flag.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.slave bus
);

  logic [ADDR_W-1:0]  pcReg;
  logic [INSTR_W-1:0] irReg;
  logic [ADDR_W-1:0]  pcInc;
  logic [ADDR_W-1:0]  pcRel;
  logic [ADDR_W-1:0]  pcAbs;
  logic [ADDR_W-1:0]  branchOff;
  logic [ADDR_W-1:0]  nextPc;
  logic [ADDR_W-1:0]  tos;
  logic               stackEmpty;
  logic               stackFull;
  logic               stackErr;

  assign pcInc     = pcReg + ADDR_W'(1);
  assign branchOff = {{(ADDR_W-OFFSET_W){irReg[OFFSET_W-1]}}, irReg[OFFSET_W-1:0]};
  assign pcRel     = pcInc + branchOff;
  assign pcAbs     = irReg[ADDR_W-1:0];

  always_comb begin
    nextPc = pcInc;
    case (bus.pc_sel)
      PC_REL:  nextPc = pcRel;
      PC_ABS:  nextPc = pcAbs;
      default: nextPc = pcInc;
    endcase
    if (bus.RET) begin
`ifdef FETCH_STACK_GUARD_EN
      nextPc = stackEmpty ? pcInc : tos;
`else
      nextPc = tos;
`endif
    end
  end

  // IR samples the word at the pre-update PC, regardless of enablePC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg <= '0;
      irReg <= '0;
    end else begin
      if (bus.enablePC) pcReg <= nextPc;
      if (bus.ir_load)  irReg <= bus.imem_data;
    end
  end

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) uStack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.enablePC & bus.push),
    .pop   (bus.enablePC & bus.pop),
    .wdata (pcInc),
    .tos   (tos),
    .empty (stackEmpty),
    .full  (stackFull),
    .err   (stackErr)
  );

`ifdef FETCH_STACK_GUARD_EN
  // RET on an empty stack is an error even if the controller forgot pop.
  logic retErr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     retErr <= 1'b0;
    else if (bus.enablePC && bus.RET && stackEmpty) retErr <= 1'b1;
  end
  assign bus.stack_err = stackErr | retErr;
`else
  assign bus.stack_err = stackErr;
`endif

  assign bus.imem_addr   = pcReg;
  assign bus.pc          = pcReg;
  assign bus.allBits     = irReg;
  assign bus.stack_empty = stackEmpty;
  assign bus.stack_full  = stackFull;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a queue-based behavioural model; honours FETCH_STACK_GUARD_EN.
module tb_instr_fetch_unit;

  localparam int AW    = 12;
  localparam int IW    = 19;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [IW-1:0] exp_q[$];

  // ---------------- instruction memory model ----------------
  logic          useForced  = 1'b0;
  logic          hashMem    = 1'b0;
  logic [IW-1:0] forcedWord = '0;

  function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
    logic [IW-1:0] t;
    t = {{(IW-AW){1'b0}}, a};
    return (t * 19'd1237) ^ 19'h2A5A5;
  endfunction

  always_comb begin
    if (useForced)    bus.imem_data = forcedWord;
    else if (hashMem) bus.imem_data = memWord(bus.imem_addr);
    else              bus.imem_data = IW'(bus.imem_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [1:0] sel, input logic ps,
                       input logic pp, input logic rt, input logic irl);
    @(negedge clk);
    bus.enablePC = en;
    bus.pc_sel   = sel;
    bus.push     = ps;
    bus.pop      = pp;
    bus.RET      = rt;
    bus.ir_load  = irl;
    @(posedge clk);
    #1;
  endtask

  task automatic setIr(input logic [IW-1:0] w);
    @(negedge clk);
    useForced  = 1'b1;
    forcedWord = w;
    bus.enablePC = 1'b0; bus.pc_sel = 2'b00; bus.push = 1'b0;
    bus.pop      = 1'b0; bus.RET    = 1'b0;  bus.ir_load = 1'b1;
    @(posedge clk);
    #1;
    useForced = 1'b0;
  endtask

  task automatic setPc(input logic [AW-1:0] a);
    setIr({{(IW-AW){1'b0}}, a});
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    bus.enablePC = 1'b0; bus.pc_sel = 2'b00; bus.push = 1'b0;
    bus.pop      = 1'b0; bus.RET    = 1'b0;  bus.ir_load = 1'b0;
    hashMem = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    tests++; if (bus.pc !== 12'h000) begin fails++; $display("FAIL por_pc: got %h expected %h", bus.pc, 12'h000); end
    tests++; if (bus.allBits !== 19'h0) begin fails++; $display("FAIL por_ir: got %h expected %h", bus.allBits, 19'h0); end
    tests++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0 || bus.stack_err !== 1'b0) begin
      fails++; $display("FAIL por_flags: got e%b f%b x%b expected e1 f0 x0", bus.stack_empty, bus.stack_full, bus.stack_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    tests++; if (bus.pc !== 12'h003 || bus.stack_empty !== 1'b0) begin
      fails++; $display("FAIL pre_reset: got pc %h empty %b expected pc 003 empty 0", bus.pc, bus.stack_empty); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.pc !== 12'h000 || bus.imem_addr !== 12'h000) begin
      fails++; $display("FAIL async_pc: got pc %h addr %h expected 000", bus.pc, bus.imem_addr); end
    tests++; if (bus.allBits !== 19'h0) begin fails++; $display("FAIL async_ir: got %h expected %h", bus.allBits, 19'h0); end
    tests++; if (bus.stack_empty !== 1'b1 || bus.stack_err !== 1'b0) begin
      fails++; $display("FAIL async_flags: got e%b x%b expected e1 x0", bus.stack_empty, bus.stack_err); end
    bus.enablePC = 1'b0; bus.push = 1'b0; bus.ir_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [IW-1:0] e;
    applyReset();
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(IW'(k - 1));
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      tests++; if (bus.pc !== AW'(k)) begin fails++; $display("FAIL seq_pc: got %h expected %h", bus.pc, AW'(k)); end
      tests++; if (bus.allBits !== e) begin fails++; $display("FAIL seq_ir: got %h expected %h", bus.allBits, e); end
    end
    setPc(12'hFFF);
    tests++; if (bus.imem_addr !== 12'hFFF) begin fails++; $display("FAIL wrap_setup: got %h expected %h", bus.imem_addr, 12'hFFF); end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (bus.pc !== 12'h000) begin fails++; $display("FAIL wrap_pc: got %h expected %h", bus.pc, 12'h000); end
    tests++; if (bus.allBits !== 19'h00FFF) begin fails++; $display("FAIL wrap_ir: got %h expected %h", bus.allBits, 19'h00FFF); end
  endtask

  task automatic test_branch();
    applyReset();
    setPc(12'h010);
    setIr(19'h001F0);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'h001) begin fails++; $display("FAIL rel_neg: got %h expected %h", bus.pc, 12'h001); end
    setIr(19'h00ABC);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'hABC) begin fails++; $display("FAIL abs: got %h expected %h", bus.pc, 12'hABC); end
    setIr(19'h0007F);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'hB3C) begin fails++; $display("FAIL rel_pos: got %h expected %h", bus.pc, 12'hB3C); end
    setPc(12'hFFE);
    setIr(19'h00005);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'h004) begin fails++; $display("FAIL rel_wrap: got %h expected %h", bus.pc, 12'h004); end
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'h005) begin fails++; $display("FAIL sel11: got %h expected %h", bus.pc, 12'h005); end
  endtask

  task automatic test_call_return();
    applyReset();
    setPc(12'h020);
    setIr(19'h00345);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'h345 || bus.stack_empty !== 1'b0) begin
      fails++; $display("FAIL call: got pc %h empty %b expected pc 345 empty 0", bus.pc, bus.stack_empty); end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (bus.pc !== 12'h021 || bus.stack_empty !== 1'b1) begin
      fails++; $display("FAIL ret: got pc %h empty %b expected pc 021 empty 1", bus.pc, bus.stack_empty); end
  endtask

  task automatic test_overflow();
    applyReset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.stack_full !== 1'b1 || bus.stack_err !== 1'b0 || bus.pc !== AW'(DEPTH)) begin
      fails++; $display("FAIL full: got f%b x%b pc %h expected f1 x0 pc %h", bus.stack_full, bus.stack_err, bus.pc, AW'(DEPTH)); end
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    setPc(12'h200);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef FETCH_STACK_GUARD_EN
    tests++; if (bus.stack_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b expected 1", bus.stack_err); end
    tests++; if (bus.pc !== 12'h008) begin fails++; $display("FAIL ovf_tos: got %h expected %h", bus.pc, 12'h008); end
    applyReset();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (bus.pc !== 12'h001 || bus.stack_err !== 1'b1 || bus.stack_empty !== 1'b1) begin
      fails++; $display("FAIL udf: got pc %h x%b e%b expected pc 001 x1 e1", bus.pc, bus.stack_err, bus.stack_empty); end
`else
    tests++; if (bus.stack_err !== 1'b0) begin fails++; $display("FAIL ovf_err: got %b expected 0", bus.stack_err); end
    tests++; if (bus.pc !== 12'h009) begin fails++; $display("FAIL ovf_tos: got %h expected %h", bus.pc, 12'h009); end
`endif
  endtask

  task automatic test_swap_hold();
    applyReset();
    setPc(12'h0FF);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    setPc(12'h050);
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (bus.pc !== 12'h100 || bus.stack_empty !== 1'b0 || bus.stack_full !== 1'b0) begin
      fails++; $display("FAIL swap: got pc %h e%b f%b expected pc 100 e0 f0", bus.pc, bus.stack_empty, bus.stack_full); end
    drive(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.pc !== 12'h100) begin fails++; $display("FAIL hold_pc: got %h expected %h", bus.pc, 12'h100); end
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (bus.pc !== 12'h051 || bus.stack_empty !== 1'b1) begin
      fails++; $display("FAIL hold_sp: got pc %h empty %b expected pc 051 empty 1", bus.pc, bus.stack_empty); end
  endtask

  task automatic test_random();
    logic          en, ps, pp, rt, irl;
    logic [1:0]    sel;
    logic [AW-1:0] mPc, nPc, tos;
    logic [IW-1:0] mIr;
    logic [AW-1:0] mStack[$];
    int            op, off, sz;
    applyReset();
    hashMem = 1'b1;
    mPc = '0;
    mIr = '0;
    for (int n = 0; n < 300; n++) begin
      sz  = mStack.size();
      en  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      irl = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 5);
      ps = 1'b0; pp = 1'b0; rt = 1'b0;
      case (op)
        1: ps = (sz < DEPTH);
        2: begin pp = (sz > 0); rt = pp; end
        3: pp = (sz > 0);
        4: begin ps = (sz > 0); pp = ps; end
        5: begin ps = (sz > 0); pp = ps; rt = ps; end
        default: ;
      endcase
      if (!en) {ps, pp, rt} = 3'($urandom_range(0, 7));
      // Model: stack is a queue whose last element is the top.
      tos = (sz > 0) ? mStack[sz-1] : '0;
      off = mIr[8] ? int'(mIr[8:0]) - 512 : int'(mIr[8:0]);
      if (!en)           nPc = mPc;
      else if (rt)       nPc = tos;
      else if (sel == 1) nPc = AW'(int'(mPc) + 1 + off);
      else if (sel == 2) nPc = mIr[AW-1:0];
      else               nPc = AW'(int'(mPc) + 1);
      if (en) begin
        if (ps && pp)  mStack[sz-1] = AW'(int'(mPc) + 1);
        else if (ps)   mStack.push_back(AW'(int'(mPc) + 1));
        else if (pp)   void'(mStack.pop_back());
      end
      if (irl) mIr = memWord(mPc);
      mPc = nPc;
      drive(en, sel, ps, pp, rt, irl);
      tests++; if (bus.pc !== mPc || bus.imem_addr !== mPc) begin
        fails++; $display("FAIL rnd_pc[%0d]: got pc %h addr %h expected %h", n, bus.pc, bus.imem_addr, mPc); end
      tests++; if (bus.allBits !== mIr) begin fails++; $display("FAIL rnd_ir[%0d]: got %h expected %h", n, bus.allBits, mIr); end
      tests++; if (bus.stack_empty !== (mStack.size() == 0) || bus.stack_full !== (mStack.size() == DEPTH) || bus.stack_err !== 1'b0) begin
        fails++; $display("FAIL rnd_flags[%0d]: got e%b f%b x%b expected e%b f%b x0", n, bus.stack_empty, bus.stack_full,
                          bus.stack_err, (mStack.size() == 0), (mStack.size() == DEPTH)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.enablePC = 1'b0; bus.pc_sel = 2'b00; bus.push = 1'b0;
    bus.pop      = 1'b0; bus.RET    = 1'b0;  bus.ir_load = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_call_return();
    test_overflow();
    test_swap_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage of the 19-bit processor. Holds the program counter, drives the instruction-memory address, captures the returned word into the instruction register (IR) that feeds the controller's `allBits` input, and keeps a hardware return-address stack serving the controller's `push`, `pop` and `RET` strobes. All next-PC selection happens here; the controller only issues strobes.

## Interface

**Parameters**
- `ADDR_W`, default 12: PC and instruction-memory address width.
- `INSTR_W`, default 19: instruction width; must match the controller's `allBits`.
- `STACK_DEPTH`, default 8: return-stack entries; must be a power of two, at least 2.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enablePC`, in, 1: from the controller; commits the next PC and stack action this cycle.
- `pc_sel`, in, 2: next-PC source when `RET`=0.
  - 00: PC+1
  - 01: PC+1+sext(IR[8:0])
  - 10: IR[ADDR_W-1:0]
  - 11: PC+1
- `push`, in, 1: push PC+1 (call).
- `pop`, in, 1: pop top of stack (TOS).
- `RET`, in, 1: next PC = TOS. The controller asserts `RET` together with `pop`.
- `ir_load`, in, 1: capture `imem_data` into IR.
- `imem_addr`, out, ADDR_W: combinationally equal to PC.
- `imem_data`, in, INSTR_W: combinational read data for `imem_addr`.
- `allBits`, out, INSTR_W: IR contents.
- `pc`, out, ADDR_W: current PC.
- `stack_empty`, out, 1: SP==0.
- `stack_full`, out, 1: SP==STACK_DEPTH.
- `stack_err`, out, 1: sticky error flag. Exists only under the macro in Configuration; tied 0 otherwise.

## Operation

- **Registers:** PC (ADDR_W bits), IR (INSTR_W bits), SP (0..STACK_DEPTH, clog2(DEPTH)+1 bits), and a stack array of STACK_DEPTH × ADDR_W.
- **Stack layout:** TOS = `stack[SP-1]`.
- **Address arithmetic:** all PC math is modulo 2^ADDR_W. PC = 2^ADDR_W−1 with PC+1 wraps to 0. The branch offset is a 9-bit two's-complement value, sign-extended.
- **`enablePC`=0:** PC, SP and stack hold; `push`, `pop` and `RET` are ignored.
- **`enablePC`=1, next PC:**
  - If `RET`: next PC = TOS.
  - Otherwise: next PC is chosen by `pc_sel`.
- **`enablePC`=1, stack action:**
  - `push` only: `stack[SP]` ← PC+1, SP ← SP+1.
  - `pop` only: SP ← SP−1.
  - `push` and `pop` together: `stack[SP-1]` ← PC+1, SP unchanged, TOS read before overwrite (swap).
- **IR:** loads `imem_data` whenever `ir_load`=1, independent of `enablePC`. It therefore captures the word at the pre-update PC.
- **Reset values:** PC=0, IR=0, SP=0, all stack entries 0, `stack_empty`=1, `stack_full`=0, `stack_err`=0. Reset mid-operation discards all stack contents immediately.

## Timing

- PC, IR, SP and the stack update on the rising `clk` edge.
- All outputs are registered, except `imem_addr`, which mirrors the PC register.
- Fetch latency:
  - PC change at edge N puts the new address on `imem_addr` after edge N.
  - `ir_load` at edge N+1 makes the word visible on `allBits` after edge N+1.
- `RET` reads TOS combinationally in the same cycle. The popped value becomes PC at the same edge at which SP decrements.
- `stack_full` and `stack_empty` reflect SP after the edge.

## Configuration

**`FETCH_STACK_GUARD_EN`**
- **Defined:**
  - Push when full (without `pop`) is dropped: SP and stack unchanged, `stack_err` set.
  - Pop or `RET` when empty: SP stays 0, next PC = PC+1 instead of TOS, `stack_err` set.
  - PC otherwise still updates normally.
  - `stack_err` is sticky until reset.
- **Undefined:**
  - SP indexing wraps modulo STACK_DEPTH.
  - Overflow overwrites the oldest entry.
  - Underflow returns whatever entry is indexed.
  - `stack_full` and `stack_empty` still computed; `stack_err` = 0.

## Structure

- **Package `fetch_pkg`:** `pc_sel` encodings (`PC_INC`, `PC_REL`, `PC_ABS`), default ADDR_W/INSTR_W, and the branch-offset width constant (9).
- **Sub-module `return_stack`:** array, SP, full/empty, and guard logic. Inputs: `push`, `pop`, write data. Outputs: TOS and flags.

## Test plan

- **Reset:** assert `rst_n`=0 mid-run after 3 pushes → PC=0, `allBits`=0, `stack_empty`=1, `stack_err`=0 immediately, without waiting for a clock.
- **Sequential fetch:** `enablePC`=1, `pc_sel`=00, `ir_load`=1, memory word = address → `allBits` equals 0,1,2,… one cycle behind `pc`. PC=0xFFF wraps to 0x000.
- **Relative branch:**
  - PC=0x010, IR[8:0]=9'h1F0 (−16), `pc_sel`=01 → PC=0x001.
  - `pc_sel`=10 with IR[11:0]=0xABC → PC=0xABC.
- **Call/return:** PC=0x020 with `push`, `pc_sel`=10 → PC=target, TOS=0x021. Later `RET`+`pop` → PC=0x021, `stack_empty`=1.
- **Overflow (guard defined):** 9 pushes at DEPTH=8 → `stack_full`=1 after the 8th, 9th ignored, `stack_err`=1. Without the macro, the 9th overwrites entry 0 and `stack_err`=0.
- **Swap and hold:**
  - `push`+`pop` with TOS=0x100 at PC=0x050 and `RET`=1 → PC=0x100, TOS=0x051, SP unchanged.
  - `enablePC`=0 with `push` asserted → no change to PC or SP.
